// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states and the
// NOP control word loaded into ID/EX on a bubble.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_MULTI = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int CTRL_W = 8;
    localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-facing signals of the sequencing controller: ID/EX status in,
// register enables and squash controls out.
interface pipeline_ctrl_if #(
    parameter int REG_ADDR_W = 3
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic                  id_multi;
    logic                  ex_valid;
    logic                  ex_load;
    logic                  ex_wr_en;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_branch_taken;
    logic                  halt_req;
    logic                  pc_en;
    logic                  ifid_en;
    logic                  idex_en;
    logic                  idex_bubble;
    logic                  ifid_flush;
    logic                  busy;
    logic [1:0]            state_o;

    // master: the controller; slave: the pipeline datapath it sequences
    modport master (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_multi,
               ex_valid, ex_load, ex_wr_en, ex_rd_addr, ex_branch_taken, halt_req,
        output pc_en, ifid_en, idex_en, idex_bubble, ifid_flush, busy, state_o
    );

    modport slave (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_multi,
               ex_valid, ex_load, ex_wr_en, ex_rd_addr, ex_branch_taken, halt_req,
        input  pc_en, ifid_en, idex_en, idex_bubble, ifid_flush, busy, state_o
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: an ID source matches the destination of
// a load still sitting in EX.
module hazard_detect #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  ex_valid,
    input  logic                  ex_load,
    input  logic                  ex_wr_en,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  load_use
);

    logic rs_hit, rt_hit;

    assign rs_hit   = id_rs_used && (id_rs_addr == ex_rd_addr);
    assign rt_hit   = id_rt_used && (id_rt_addr == ex_rd_addr);
    assign load_use = id_valid && ex_valid && ex_load && ex_wr_en && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: owns PC / IF/ID / ID/EX advance, handling
// taken-branch flushes, load-use stalls, multi-cycle EX ops and halts.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 3,
    parameter int MULTI_LAT   = 4,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic           clock,
    input  logic           reset,
    pipeline_ctrl_if.master pif
);

    // Counters load "remaining cycles minus one" so cnt==0 marks the last cycle
    localparam logic [3:0] FLUSH_INIT = 4'((FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0);
    localparam logic [3:0] MULTI_INIT = 4'(MULTI_LAT - 2);

    state_e     state;
    logic [3:0] cnt;
    logic       load_use;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .id_valid   (pif.id_valid),
        .id_rs_addr (pif.id_rs_addr),
        .id_rt_addr (pif.id_rt_addr),
        .id_rs_used (pif.id_rs_used),
        .id_rt_used (pif.id_rt_used),
        .ex_valid   (pif.ex_valid),
        .ex_load    (pif.ex_load),
        .ex_wr_en   (pif.ex_wr_en),
        .ex_rd_addr (pif.ex_rd_addr),
        .load_use   (load_use)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pif.ex_branch_taken) begin
                        if (FLUSH_DEPTH > 1) begin
                            state <= ST_FLUSH;
                            cnt   <= FLUSH_INIT;
                        end
                    end else if (pif.halt_req) begin
                        state <= ST_HALT;
                    end else if (!load_use && pif.id_valid && pif.id_multi) begin
                        state <= ST_MULTI;
                        cnt   <= MULTI_INIT;
                    end
                end
                ST_FLUSH, ST_MULTI: begin
                    if (cnt == '0) state <= ST_RUN;
                    else           cnt   <= cnt - 4'd1;
                end
                ST_HALT: begin
                    if (!pif.halt_req) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Outputs are held at 0 for the whole time reset is low
    always_comb begin
        pif.pc_en       = 1'b0;
        pif.ifid_en     = 1'b0;
        pif.idex_en     = 1'b0;
        pif.idex_bubble = 1'b0;
        pif.ifid_flush  = 1'b0;
        pif.busy        = 1'b0;
        pif.state_o     = 2'd0;
        if (reset) begin
            pif.busy    = (state != ST_RUN);
            pif.state_o = state;
            case (state)
                ST_RUN: begin
                    if (pif.ex_branch_taken) begin
                        pif.pc_en       = 1'b1;
                        pif.ifid_en     = 1'b1;
                        pif.idex_en     = 1'b1;
                        pif.idex_bubble = 1'b1;
                        pif.ifid_flush  = 1'b1;
                    end else if (pif.halt_req) begin
                        pif.pc_en = 1'b0;
                    end else if (load_use) begin
                        pif.idex_en     = 1'b1;
                        pif.idex_bubble = 1'b1;
                    end else begin
                        pif.pc_en   = 1'b1;
                        pif.ifid_en = 1'b1;
                        pif.idex_en = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    pif.pc_en       = 1'b1;
                    pif.ifid_en     = 1'b1;
                    pif.idex_en     = 1'b1;
                    pif.idex_bubble = 1'b1;
                    pif.ifid_flush  = 1'b1;
                end
                default: pif.pc_en = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MULTI_LAT=4, FLUSH_DEPTH=2): inputs are
// driven after the falling edge and outputs checked 1ns later.
module tb_pipeline_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    pipeline_ctrl_if #(.REG_ADDR_W(3)) pif ();

    pipeline_ctrl #(.REG_ADDR_W(3), .MULTI_LAT(4), .FLUSH_DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .pif   (pif.master)
    );

    // {pc_en, ifid_en, idex_en, idex_bubble, ifid_flush, busy, state_o[1:0]}
    localparam logic [7:0] O_ZERO  = 8'b00000_0_00;
    localparam logic [7:0] O_ADV   = 8'b11100_0_00;
    localparam logic [7:0] O_STALL = 8'b00110_0_00;
    localparam logic [7:0] O_BR    = 8'b11111_0_00;
    localparam logic [7:0] O_FLUSH = 8'b11111_1_01;
    localparam logic [7:0] O_MULTI = 8'b00000_1_10;
    localparam logic [7:0] O_HALT  = 8'b00000_1_11;

    function automatic logic [7:0] outs();
        return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.idex_bubble,
                pif.ifid_flush, pif.busy, pif.state_o};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pif.id_valid = 0; pif.id_rs_addr = 0; pif.id_rt_addr = 0;
        pif.id_rs_used = 0; pif.id_rt_used = 0; pif.id_multi = 0;
        pif.ex_valid = 0; pif.ex_load = 0; pif.ex_wr_en = 0; pif.ex_rd_addr = 0;
        pif.ex_branch_taken = 0; pif.halt_req = 0;
    endtask

    // Load of r3 in EX; ID reads r3 through rs or rt
    task automatic load_use_inputs(input logic via_rt);
        pif.ex_valid = 1; pif.ex_load = 1; pif.ex_wr_en = 1; pif.ex_rd_addr = 3'd3;
        pif.id_valid = 1;
        pif.id_rs_addr = via_rt ? 3'd5 : 3'd3; pif.id_rs_used = 1;
        pif.id_rt_addr = via_rt ? 3'd3 : 3'd6; pif.id_rt_used = 1;
    endtask

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    initial begin
        idle();
        // reset low with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            {pif.id_valid, pif.id_rs_used, pif.id_rt_used, pif.id_multi,
             pif.ex_valid, pif.ex_load, pif.ex_wr_en, pif.ex_branch_taken} = 8'($urandom);
            pif.halt_req = 1'($urandom);
            pif.id_rs_addr = 3'($urandom); pif.id_rt_addr = 3'($urandom);
            pif.ex_rd_addr = 3'($urandom);
            #1 chk("reset_outs", outs(), O_ZERO);
        end
        @(negedge clock); reset = 1; idle();
        #1 chk("idle_adv", outs(), O_ADV);

        // load-use via rs: one stall, then advance with EX holding the bubble
        cyc(); load_use_inputs(0); #1 chk("lu_rs_stall", outs(), O_STALL);
        cyc(); idle(); pif.id_valid = 1; pif.id_rs_addr = 3; pif.id_rs_used = 1;
        #1 chk("lu_rs_clear", outs(), O_ADV);
        cyc(); load_use_inputs(1); #1 chk("lu_rt_stall", outs(), O_STALL);
        // matching address but source unused or EX not a load: no stall
        cyc(); load_use_inputs(1); pif.id_rt_used = 0; #1 chk("lu_unused", outs(), O_ADV);
        cyc(); load_use_inputs(0); pif.ex_load = 0; #1 chk("lu_not_load", outs(), O_ADV);

        // branch with concurrent load-use: branch wins, 2 flush cycles
        cyc(); load_use_inputs(0); pif.ex_branch_taken = 1; #1 chk("br_detect", outs(), O_BR);
        cyc(); pif.ex_branch_taken = 0; #1 chk("br_flush", outs(), O_FLUSH);
        cyc(); idle(); #1 chk("br_done", outs(), O_ADV);

        // multi-cycle op with halt raised mid-way
        cyc(); pif.id_valid = 1; pif.id_multi = 1; #1 chk("mul_issue", outs(), O_ADV);
        cyc(); idle(); #1 chk("mul_hold1", outs(), O_MULTI);
        cyc(); pif.halt_req = 1; #1 chk("mul_hold2", outs(), O_MULTI);
        cyc(); #1 chk("mul_hold3", outs(), O_MULTI);
        cyc(); #1 chk("halt_in_run", outs(), O_ZERO);
        cyc(); #1 chk("halt_1", outs(), O_HALT);
        cyc(); #1 chk("halt_2", outs(), O_HALT);
        cyc(); pif.halt_req = 0; #1 chk("halt_drop", outs(), O_HALT);
        cyc(); #1 chk("halt_resume", outs(), O_ADV);

        // branch and halt together: flush runs first, then halt
        cyc(); pif.ex_branch_taken = 1; pif.halt_req = 1; #1 chk("brh_detect", outs(), O_BR);
        cyc(); #1 chk("brh_flush", outs(), O_FLUSH);
        cyc(); pif.ex_branch_taken = 0; #1 chk("brh_run_halt", outs(), O_ZERO);
        cyc(); #1 chk("brh_halt", outs(), O_HALT);
        cyc(); idle(); #1 chk("brh_halt_drop", outs(), O_HALT);
        cyc(); #1 chk("brh_resume", outs(), O_ADV);

        // reset in the second MULTI cycle aborts with no residual hold
        cyc(); pif.id_valid = 1; pif.id_multi = 1; #1 chk("mr_issue", outs(), O_ADV);
        cyc(); idle(); #1 chk("mr_hold1", outs(), O_MULTI);
        @(negedge clock); #1 chk("mr_hold2", outs(), O_MULTI);
        reset = 0; #1 chk("mr_reset", outs(), O_ZERO);
        cyc(); chk("mr_reset_edge", outs(), O_ZERO);
        @(negedge clock); reset = 1; #1 chk("mr_release", outs(), O_ADV);
        cyc(); #1 chk("mr_no_hold", outs(), O_ADV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencing controller for the processor's IF/ID and ID/EX pipeline registers. It detects load-use hazards, taken-branch flushes, multi-cycle EX operations and external halt requests. It drives the PC, IF/ID and ID/EX enables plus the bubble and flush controls. In a bubble, the ID/EX control bits are loaded with 0, which is a NOP. It sits beside the ID stage and is the single authority on pipeline advance.

## Interface
Parameters:
- REG_ADDR_W, 3, register-address width
- MULTI_LAT, 4, total EX cycles of a multi-cycle op (legal: 2..16)
- FLUSH_DEPTH, 2, cycles of squash after a taken branch, counting the detection cycle (legal: 1..8)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_rs_addr, id_rt_addr  in  REG_ADDR_W  ID source registers
- id_rs_used, id_rt_used  in  1  source actually read
- id_multi  in  1  ID instruction is multi-cycle
- ex_valid, ex_load, ex_wr_en  in  1  EX instruction valid / is load / writes a register
- ex_rd_addr  in  REG_ADDR_W  EX destination register
- ex_branch_taken  in  1  EX resolved a taken branch this cycle
- halt_req  in  1  external halt (level)
- pc_en, ifid_en, idex_en  out  1  register load enables
- idex_bubble  out  1  load 0s into the ID/EX control bits
- ifid_flush  out  1  load NOP into IF/ID
- busy  out  1  state != RUN
- state_o  out  2  current state encoding

## Operation
- States: RUN=0, FLUSH=1, MULTI=2, HALT=3. One shared down-counter `cnt` of 4 bits.
- load_use = id_valid & ex_valid & ex_load & ex_wr_en & ((id_rs_used & id_rs_addr==ex_rd_addr) | (id_rt_used & id_rt_addr==ex_rd_addr)).
- RUN priority, highest first:
  1. ex_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=1. If FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-2; otherwise stay in RUN.
  2. halt_req: all enables 0. Go to HALT.
  3. load_use: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1. Stay in RUN. The hazard clears the next cycle because EX then holds the bubble.
  4. id_valid & id_multi: normal advance with all enables 1. Go to MULTI with cnt=MULTI_LAT-2.
  5. Otherwise: all enables 1, bubble 0, flush 0.
- FLUSH: pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=1. At cnt==0 go to RUN; otherwise decrement cnt. ex_branch_taken, halt_req and load_use are ignored.
- MULTI: pc_en=0, ifid_en=0, idex_en=0 (ID/EX holds the multi op), no bubble. At cnt==0 go to RUN; otherwise decrement cnt. Branch, halt and load_use are ignored. A pending halt_req is taken in RUN afterwards.
- HALT: all enables 0, bubble 0, flush 0. Go to RUN on the first cycle halt_req==0. Resumption is a normal RUN cycle.
- Outputs are combinational from state and inputs. state_o and busy are from state only.

## Timing
- While reset==0: state=RUN, cnt=0. All outputs are forced to 0: pc_en, ifid_en, idex_en, idex_bubble, ifid_flush, busy and state_o.
- Reset deassert: the first rising edge evaluates RUN rules.
- Reset asserted mid-FLUSH, mid-MULTI or mid-HALT aborts immediately with no residual count.
- Taken branch: bubble/flush asserted for exactly FLUSH_DEPTH consecutive cycles.
- Multi op: ID/EX is held for exactly MULTI_LAT-1 cycles after issue, so it is resident in EX for MULTI_LAT cycles.
- Load-use: exactly one stall/bubble cycle per hazard.
- Branch and load_use in the same RUN cycle: the branch wins and no stall occurs.
- Branch and halt_req in the same cycle: the flush sequence runs first, then HALT.

## Structure
- Shared package pipe_ctrl_pkg: 2-bit state encodings (RUN/FLUSH/MULTI/HALT) and the NOP control-word constant (all 0) used by the pipeline registers.
- Sub-module hazard_detect: purely combinational load_use comparator, reusable for a future second issue port.
- Top level: state register, cnt register and output decode.

## Test plan
- Reset held low with random inputs: all outputs 0. After release with idle inputs: pc_en=ifid_en=idex_en=1, busy=0.
- Load r3 in EX (ex_load=1, ex_rd_addr=3), ID reads rs=3: one cycle of pc_en=0, ifid_en=0, idex_bubble=1. The next cycle, with EX now the bubble, shows full advance.
- ex_branch_taken=1 with FLUSH_DEPTH=2: ifid_flush=idex_bubble=1 for 2 cycles, state_o 0→1→0. A load_use applied concurrently produces no stall.
- id_multi issue with MULTI_LAT=4: one advance cycle, then idex_en=0 for 3 cycles with state_o=2, then RUN.
- halt_req raised during MULTI: MULTI completes, then HALT (state_o=3, enables 0) until halt_req drops. The next cycle is RUN with enables 1.
- Reset pulsed low in the second MULTI cycle: outputs go to 0 immediately. After release, state is RUN and there is no residual hold.
